// File: rtl/ascon_pack.sv
// Shared types and helpers for the ASCON permutation engine.
package ascon_pack;

    typedef logic [319:0] type_state;

    typedef enum logic [1:0] {
        PERM_P12  = 2'b00,
        PERM_P8   = 2'b01,
        PERM_P6   = 2'b10,
        PERM_RSVD = 2'b11
    } type_perm_mode;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } type_fsm;

    // Round constant for round r: upper nibble counts down, lower nibble counts up.
    function automatic logic [7:0] round_const(input logic [3:0] r);
        return {4'd15 - r, r};
    endfunction

    // Rounds per call; the reserved encoding runs the full p12.
    function automatic logic [3:0] n_rounds(input type_perm_mode mode);
        case (mode)
            PERM_P8: return 4'd8;
            PERM_P6: return 4'd6;
            default: return 4'd12;
        endcase
    endfunction

    function automatic logic [63:0] ror64(input logic [63:0] x, input int n);
        return (x >> n) | (x << (64 - n));
    endfunction

endpackage

// File: rtl/ascon_round.sv
// One combinational ASCON round: constant addition, 5-bit S-box layer, linear layer.
module ascon_round
    import ascon_pack::*;
(
    input  logic [319:0] state_i,
    input  logic [3:0]   round_i,
    output logic [319:0] state_o
);

    logic [63:0] c0, c1, c2, c3, c4;
    logic [63:0] a0, a1, a2, a3, a4;
    logic [63:0] b0, b1, b2, b3, b4;
    logic [63:0] d0, d1, d2, d3, d4;

    // Bitsliced S-box followed by the per-word diffusion layer.
    always_comb begin
        c0 = state_i[319:256];
        c1 = state_i[255:192];
        c2 = state_i[191:128] ^ {56'b0, round_const(round_i)};
        c3 = state_i[127:64];
        c4 = state_i[63:0];

        a0 = c0 ^ c4;
        a1 = c1;
        a2 = c2 ^ c1;
        a3 = c3;
        a4 = c4 ^ c3;

        b0 = a0 ^ (~a1 & a2);
        b1 = a1 ^ (~a2 & a3);
        b2 = a2 ^ (~a3 & a4);
        b3 = a3 ^ (~a4 & a0);
        b4 = a4 ^ (~a0 & a1);

        d0 = b0 ^ b4;
        d1 = b1 ^ b0;
        d2 = ~b2;
        d3 = b3 ^ b2;
        d4 = b4;

        state_o = {d0 ^ ror64(d0, 19) ^ ror64(d0, 28),
                   d1 ^ ror64(d1, 61) ^ ror64(d1, 39),
                   d2 ^ ror64(d2, 1)  ^ ror64(d2, 6),
                   d3 ^ ror64(d3, 10) ^ ror64(d3, 17),
                   d4 ^ ror64(d4, 7)  ^ ror64(d4, 41)};
    end

endmodule

// File: rtl/ascon_perm_engine.sv
// Self-sequencing ASCON permutation: p12/p8/p6, UNROLL rounds per clock,
// begin XORs on the launch edge and end XORs on the final edge of a call.
//
//   state   | meaning
//   --------+-------------------------------------------------------------
//   ST_IDLE | register holds; start_i launches a call (first rounds written)
//   ST_RUN  | UNROLL rounds per edge; the edge finishing round 11 ends it
module ascon_perm_engine
    import ascon_pack::*;
#(
    parameter int UNROLL = 1,
    parameter int RATE_W = 64
) (
    input  logic              clock_i,
    input  logic              resetb_i,
    input  logic              start_i,
    input  logic [1:0]        mode_i,
    input  logic              load_i,
    input  logic [319:0]      state_i,
    input  logic [RATE_W-1:0] data_i,
    input  logic [127:0]      key_i,
    input  logic              en_xor_data_i,
    input  logic              en_xor_key_i,
    input  logic              en_xor_key_end_i,
    input  logic              en_xor_lsb_i,
    output logic [319:0]      state_o,
    output logic              busy_o,
    output logic              done_o,
    output logic [3:0]        round_o
);

    if (UNROLL != 1 && UNROLL != 2) begin : g_bad_unroll
        $error("ascon_perm_engine: UNROLL must be 1 or 2");
    end
    if (RATE_W != 64 && RATE_W != 128) begin : g_bad_rate
        $error("ascon_perm_engine: RATE_W must be 64 or 128");
    end

    type_fsm       fsm_q, fsm_d;
    type_state     state_q, state_d;
    logic [3:0]    round_q, round_d;
    logic          done_q, done_d;
    logic [1:0]    end_en_q, end_en_d;   // {key_end, lsb}; the begin enables act only on the launch edge

    type_perm_mode mode_sel;
    logic [3:0]    r_first;
    logic [3:0]    round_base;
    logic          accept;
    logic          last;
    type_state     src, begin_s, chain_in, end_s;
    type_state     data_mask, key_mask;
    logic [319:0]  stage [0:UNROLL];

    // Rate-dependent placement of the data block and the begin key.
    if (RATE_W == 128) begin : g_rate128
        assign data_mask = {data_i, 192'b0};
        assign key_mask  = {128'b0, key_i, 64'b0};
    end else begin : g_rate64
        assign data_mask = {data_i, 256'b0};
        assign key_mask  = {64'b0, key_i, 128'b0};
    end

    // Select round-chain input and round index; apply begin/end XORs.
    always_comb begin
        mode_sel   = type_perm_mode'(mode_i);
        r_first    = 4'd12 - n_rounds(mode_sel);
        accept     = (fsm_q == ST_IDLE) && start_i;
        src        = load_i ? state_i : state_q;
        begin_s    = src ^ (en_xor_data_i ? data_mask : '0) ^ (en_xor_key_i ? key_mask : '0);
        chain_in   = accept ? begin_s : state_q;
        round_base = accept ? r_first : round_q;
        last       = (round_base + 4'(UNROLL)) == 4'd12;
        end_s      = stage[UNROLL] ^ (end_en_q[1] ? {192'b0, key_i} : '0) ^ {319'b0, end_en_q[0]};
    end

    assign stage[0] = chain_in;

    for (genvar g = 0; g < UNROLL; g++) begin : g_round
        ascon_round u_round (
            .state_i (stage[g]),
            .round_i (round_base + 4'(g)),
            .state_o (stage[g+1])
        );
    end

    // Next-state logic for the call sequencer.
    always_comb begin
        fsm_d    = fsm_q;
        state_d  = state_q;
        round_d  = round_q;
        done_d   = 1'b0;
        end_en_d = end_en_q;
        case (fsm_q)
            ST_IDLE: begin
                if (start_i) begin
                    fsm_d    = ST_RUN;
                    state_d  = stage[UNROLL];
                    round_d  = r_first + 4'(UNROLL);
                    end_en_d = {en_xor_key_end_i, en_xor_lsb_i};
                end
            end
            ST_RUN: begin
                round_d = round_q + 4'(UNROLL);
                state_d = last ? end_s : stage[UNROLL];
                if (last) begin
                    fsm_d   = ST_IDLE;
                    round_d = 4'd0;
                    done_d  = 1'b1;
                end
            end
            default: fsm_d = ST_IDLE;
        endcase
    end

    // State, counter and latched-enable registers; reset aborts any call.
    always_ff @(posedge clock_i or posedge resetb_i) begin
        if (resetb_i) begin
            fsm_q    <= ST_IDLE;
            state_q  <= '0;
            round_q  <= 4'd0;
            done_q   <= 1'b0;
            end_en_q <= 2'b00;
        end else begin
            fsm_q    <= fsm_d;
            state_q  <= state_d;
            round_q  <= round_d;
            done_q   <= done_d;
            end_en_q <= end_en_d;
        end
    end

    assign state_o = state_q;
    assign busy_o  = (fsm_q == ST_RUN);
    assign done_o  = done_q;
    assign round_o = round_q;

endmodule

// File: tb/tb_ascon_perm_engine.sv
// Scoreboard bench for ascon_perm_engine over three UNROLL/RATE_W configurations.
module tb_ascon_perm_engine;

    int n_pass  = 0;
    int n_total = 0;
    int cyc     = 0;
    logic clk   = 1'b0;

    initial forever #5 clk = ~clk;
    initial forever begin
        @(posedge clk);
        cyc <= cyc + 1;
    end

    typedef struct {
        logic [319:0] st;
        int           due;
    } exp_t;

    localparam logic [4:0] SBOX [0:31] = '{
        5'h04, 5'h0b, 5'h1f, 5'h14, 5'h1a, 5'h15, 5'h09, 5'h02,
        5'h1b, 5'h05, 5'h08, 5'h12, 5'h1d, 5'h03, 5'h06, 5'h1c,
        5'h1e, 5'h13, 5'h07, 5'h0e, 5'h00, 5'h0d, 5'h11, 5'h18,
        5'h10, 5'h0c, 5'h01, 5'h19, 5'h16, 5'h0a, 5'h0f, 5'h17};
    localparam int ROT [0:9] = '{19, 28, 61, 39, 1, 6, 10, 17, 7, 41};
    localparam logic [319:0] INIT_128 =
        {64'h80400c0600000000, 128'h000102030405060708090a0b0c0d0e0f, 128'h0};
    localparam logic [127:0] KEY_128 = 128'h000102030405060708090a0b0c0d0e0f;

    task automatic check(input string name, input logic [319:0] act, input logic [319:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h required %h", name, act, exp);
    endtask

    task automatic chk_int(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d required %0d", name, act, exp);
    endtask

    function automatic logic [319:0] rnd320();
        logic [319:0] r = '0;
        for (int i = 0; i < 10; i++) r = {r[287:0], 32'($urandom())};
        return r;
    endfunction

    function automatic logic [63:0] m_ror(input logic [63:0] x, input int n);
        return (x >> n) | (x << (64 - n));
    endfunction

    // Reference round: table S-box applied column by column, then diffusion.
    function automatic logic [319:0] m_round(input logic [319:0] s, input int r);
        logic [63:0] w [5];
        logic [63:0] o [5];
        logic [4:0]  v, y;
        logic [319:0] res;
        for (int i = 0; i < 5; i++) w[i] = s[319-64*i -: 64];
        w[2][7:0] = w[2][7:0] ^ 8'(((15 - r) << 4) + r);
        for (int b = 0; b < 64; b++) begin
            v = {w[0][b], w[1][b], w[2][b], w[3][b], w[4][b]};
            y = SBOX[v];
            for (int i = 0; i < 5; i++) o[i][b] = y[4-i];
        end
        for (int i = 0; i < 5; i++) o[i] = o[i] ^ m_ror(o[i], ROT[2*i]) ^ m_ror(o[i], ROT[2*i+1]);
        res = '0;
        for (int i = 0; i < 5; i++) res[319-64*i -: 64] = o[i];
        return res;
    endfunction

    function automatic int m_nrounds(input logic [1:0] m);
        return (m == 2'd1) ? 8 : (m == 2'd2) ? 6 : 12;
    endfunction

    // Whole call: en = {data, key, key_end, lsb}.
    function automatic logic [319:0] m_perm(input logic [319:0] src, input logic [127:0] data,
                                            input logic [127:0] key, input logic [1:0] m,
                                            input logic [3:0] en, input int rate);
        logic [319:0] s = src;
        int n = m_nrounds(m);
        if (en[3]) begin
            if (rate == 128) begin
                s[319:256] = s[319:256] ^ data[127:64];
                s[255:192] = s[255:192] ^ data[63:0];
            end else begin
                s[319:256] = s[319:256] ^ data[63:0];
            end
        end
        if (en[2]) begin
            if (rate == 128) s[191:64] = s[191:64] ^ key;
            else             s[255:128] = s[255:128] ^ key;
        end
        for (int r = 12 - n; r < 12; r++) s = m_round(s, r);
        if (en[1]) s[127:0] = s[127:0] ^ key;
        if (en[0]) s[0] = ~s[0];
        return s;
    endfunction

    for (genvar g = 0; g < 3; g++) begin : g_cfg
        localparam int U = (g == 1) ? 2 : 1;
        localparam int R = (g == 2) ? 128 : 64;

        logic         rst, start, load, en_d, en_k, en_ke, en_l, busy, done;
        logic [1:0]   mode;
        logic [319:0] st_in, st_out;
        logic [R-1:0] data;
        logic [127:0] key;
        logic [3:0]   rnd;
        logic [319:0] mreg;
        exp_t         q [$];
        bit           fin = 1'b0;

        ascon_perm_engine #(.UNROLL(U), .RATE_W(R)) dut (
            .clock_i          (clk),
            .resetb_i         (rst),
            .start_i          (start),
            .mode_i           (mode),
            .load_i           (load),
            .state_i          (st_in),
            .data_i           (data),
            .key_i            (key),
            .en_xor_data_i    (en_d),
            .en_xor_key_i     (en_k),
            .en_xor_key_end_i (en_ke),
            .en_xor_lsb_i     (en_l),
            .state_o          (st_out),
            .busy_o           (busy),
            .done_o           (done),
            .round_o          (rnd)
        );

        // Monitor: every done_o pulse must match the oldest outstanding call.
        initial begin : mon
            exp_t e;
            forever begin
                @(negedge clk);
                if (done === 1'b1) begin
                    if (q.size() == 0) begin
                        n_total++;
                        $display("FAIL cfg%0d unexpected_done: done_o=1 at cycle %0d, required 0", g, cyc);
                    end else begin
                        e = q.pop_front();
                        check($sformatf("cfg%0d result", g), st_out, e.st);
                        chk_int($sformatf("cfg%0d done_cycle", g), cyc, e.due);
                    end
                end
            end
        end

        // Issue one call; ign>0 re-pulses start in that RUN cycle, abt>0 resets in that cycle.
        task automatic do_call(input logic [1:0] m, input logic ld, input logic [319:0] si,
                               input logic [127:0] di, input logic [127:0] ki,
                               input logic [3:0] en, input int ign, input int abt);
            int n, len, k;
            logic [319:0] exp_s, src, tmp;
            exp_t e;
            n     = m_nrounds(m);
            len   = n / U;
            src   = ld ? si : mreg;
            exp_s = m_perm(src, di, ki, m, en, R);
            mode  = m;
            load  = ld;
            st_in = si;
            data  = di[R-1:0];
            key   = ki;
            {en_d, en_k, en_ke, en_l} = en;
            start = 1'b1;
            k     = cyc;
            e.st  = exp_s;
            e.due = k + len;
            q.push_back(e);
            for (int j = 1; j <= len; j++) begin
                @(negedge clk);
                start = 1'b0;
                if (j == abt) begin
                    rst = 1'b1;
                    q.delete();
                    mreg = '0;
                    @(negedge clk);
                    check($sformatf("cfg%0d abort_state", g), st_out, '0);
                    chk_int($sformatf("cfg%0d abort_busy", g), int'(busy), 0);
                    chk_int($sformatf("cfg%0d abort_done", g), int'(done), 0);
                    chk_int($sformatf("cfg%0d abort_round", g), int'(rnd), 0);
                    rst = 1'b0;
                    return;
                end
                if (j < len) begin
                    chk_int($sformatf("cfg%0d busy_run", g), int'(busy), 1);
                    chk_int($sformatf("cfg%0d round_o", g), int'(rnd), 12 - n + U * j);
                end else begin
                    chk_int($sformatf("cfg%0d busy_end", g), int'(busy), 0);
                    chk_int($sformatf("cfg%0d round_end", g), int'(rnd), 0);
                    mreg = exp_s;
                end
                if (j == ign) begin
                    start = 1'b1;
                    mode  = 2'b10;
                    load  = 1'b1;
                    st_in = rnd320();
                    tmp   = rnd320();
                    data  = tmp[R-1:0];
                end
            end
        endtask

        initial begin : drv
            logic [319:0] s, d;
            logic [1:0]   m;
            int           gap;
            rst = 1'b1; start = 1'b0; mode = 2'b00; load = 1'b0; st_in = '0;
            data = '0; key = '0; {en_d, en_k, en_ke, en_l} = 4'b0000; mreg = '0;
            repeat (2) @(negedge clk);
            check($sformatf("cfg%0d reset_state", g), st_out, '0);
            chk_int($sformatf("cfg%0d reset_busy", g), int'(busy), 0);
            chk_int($sformatf("cfg%0d reset_done", g), int'(done), 0);
            chk_int($sformatf("cfg%0d reset_round", g), int'(rnd), 0);
            rst = 1'b0;
            @(negedge clk);
            do_call(2'b10, 1'b1, '0, '0, '0, 4'b0000, 0, 0);
            @(negedge clk);
            do_call(2'b00, 1'b1, INIT_128, '0, KEY_128, 4'b0010, 0, 0);
            @(negedge clk);
            do_call(2'b01, 1'b0, '0, 128'h00112233445566778899aabbccddeeff, KEY_128, 4'b1000, 0, 0);
            @(negedge clk);
            do_call(2'b00, 1'b1, rnd320(), rnd320()[127:0], KEY_128, 4'b0110, 3, 0);
            @(negedge clk);
            do_call(2'b00, 1'b1, rnd320(), '0, KEY_128, 4'b0011, 0, 4);
            do_call(2'b00, 1'b0, '0, '0, KEY_128, 4'b0001, 0, 0);
            do_call(2'b01, 1'b1, rnd320(), '0, KEY_128, 4'b0010, 0, 0);
            do_call(2'b10, 1'b0, '0, '0, KEY_128, 4'b0000, 0, 0);
            for (int i = 0; i < 12; i++) begin
                s   = rnd320();
                d   = rnd320();
                m   = 2'($urandom_range(0, 3));
                do_call(m, 1'($urandom_range(0, 1)), s, d[127:0], d[255:128],
                        4'($urandom_range(0, 15)), 0, 0);
                gap = $urandom_range(0, 2);
                repeat (gap) @(negedge clk);
            end
            repeat (3) @(negedge clk);
            chk_int($sformatf("cfg%0d queue_drained", g), q.size(), 0);
            fin = 1'b1;
        end
    end

    initial begin : master
        bit all_fin = 1'b0;
        for (int t = 0; t < 20000 && !all_fin; t++) begin
            @(negedge clk);
            all_fin = g_cfg[0].fin && g_cfg[1].fin && g_cfg[2].fin;
        end
        if (!all_fin) begin
            n_total++;
            $display("FAIL timeout: drivers finished=0, required 1");
        end
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
